// File: rtl/cmem_arbiter_pkg.sv
// Shared constants for the layer-memory arbiter: memory select codes and bus widths.
package cmem_arbiter_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 20;
    localparam int SEL_W  = 3;

    localparam logic [SEL_W-1:0] CSEL_L0    = 3'b001;
    localparam logic [SEL_W-1:0] CSEL_L1    = 3'b010;
    localparam logic [SEL_W-1:0] CSEL_POOL0 = 3'b011;
    localparam logic [SEL_W-1:0] CSEL_POOL1 = 3'b100;
    localparam logic [SEL_W-1:0] CSEL_FLAT  = 3'b101;

    function automatic int wrap_inc(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/cmem_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: scans ptr, ptr+1, ... wrapping at N.
// Zero latency; no state.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    int   j;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/cmem_arbiter.sv
// Round-robin arbiter sharing the single layer-memory port among N engines,
// with short locked bursts; command at T+1, read data/rvalid at T+2.
module cmem_arbiter
    import cmem_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_LOCK = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        req,
    input  logic [N-1:0]        req_we,
    input  logic [N-1:0]        req_lock,
    input  logic [3*N-1:0]      req_sel,
    input  logic [12*N-1:0]     req_addr,
    input  logic [20*N-1:0]     req_wdata,
    output logic [N-1:0]        gnt,
    output logic [N-1:0]        rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic [SEL_W-1:0]    csel,
    output logic                crd,
    output logic                cwr,
    output logic [ADDR_W-1:0]   caddr_rd,
    output logic [ADDR_W-1:0]   caddr_wr,
    output logic [DATA_W-1:0]   cdata_wr,
    input  logic [DATA_W-1:0]   cdata_rd
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAX_LOCK + 1);

    logic [PW-1:0] ptr;
    logic          lock_vld;
    logic [PW-1:0] lock_owner;
    logic [CW-1:0] lock_cnt;
    logic [PW-1:0] rd_tag;

    logic [N-1:0]  pick_gnt;
    logic [PW-1:0] pick_idx;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    logic          lock_hold;
    logic [N-1:0]  win_gnt;
    logic [PW-1:0] win_idx;
    logic          accept;
    logic [CW-1:0] cnt_next;
    logic          keep_lock;
    logic [PW-1:0] ptr_after_win;
    logic [PW-1:0] ptr_after_owner;
    int            sel_idx;

    always_comb begin
        lock_hold       = lock_vld && req[lock_owner];
        win_gnt         = lock_hold ? (N'(1) << lock_owner) : pick_gnt;
        win_idx         = lock_hold ? lock_owner : pick_idx;
        gnt             = reset ? '0 : win_gnt;
        accept          = !reset && (|win_gnt);
        // A burst continues counting only while the owner keeps the port; a new owner starts at 1.
        cnt_next        = (lock_hold ? lock_cnt : CW'(0)) + CW'(1);
        keep_lock       = req_lock[win_idx] && (int'(cnt_next) < MAX_LOCK);
        ptr_after_win   = PW'(wrap_inc(int'(win_idx), N));
        ptr_after_owner = PW'(wrap_inc(int'(lock_owner), N));
        sel_idx         = int'(win_idx);
    end

    // Arbitration state: pointer frozen during a burst, advanced once on release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr        <= '0;
            lock_vld   <= 1'b0;
            lock_owner <= '0;
            lock_cnt   <= '0;
        end else if (accept) begin
            if (keep_lock) begin
                lock_vld   <= 1'b1;
                lock_owner <= win_idx;
                lock_cnt   <= cnt_next;
            end else begin
                lock_vld <= 1'b0;
                lock_cnt <= '0;
                ptr      <= ptr_after_win;
            end
        end else if (lock_vld) begin
            lock_vld <= 1'b0;
            lock_cnt <= '0;
            ptr      <= ptr_after_owner;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csel     <= '0;
            crd      <= 1'b0;
            cwr      <= 1'b0;
            caddr_rd <= '0;
            caddr_wr <= '0;
            cdata_wr <= '0;
            rd_tag   <= '0;
        end else begin
            crd <= 1'b0;
            cwr <= 1'b0;
            if (accept) begin
                csel <= req_sel[sel_idx*3 +: 3];
                if (req_we[win_idx]) begin
                    cwr      <= 1'b1;
                    caddr_wr <= req_addr[sel_idx*12 +: 12];
                    cdata_wr <= req_wdata[sel_idx*20 +: 20];
                end else begin
                    crd      <= 1'b1;
                    caddr_rd <= req_addr[sel_idx*12 +: 12];
                    rd_tag   <= win_idx;
                end
            end
        end
    end

    // Memory is combinational: cdata_rd is valid while crd is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= crd ? (N'(1) << rd_tag) : '0;
            if (crd) rdata <= cdata_rd;
        end
    end

endmodule

// File: tb/tb_cmem_arbiter.sv
// Directed bench for cmem_arbiter: reset, read/write paths, fairness, locked bursts and lock cap.
module tb_cmem_arbiter;
    import cmem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req, req_we, req_lock;
    logic [11:0] req_sel;
    logic [47:0] req_addr;
    logic [79:0] req_wdata;
    logic [3:0]  gnt, rvalid;
    logic [19:0] rdata, cdata_wr, cdata_rd;
    logic [2:0]  csel;
    logic        crd, cwr;
    logic [11:0] caddr_rd, caddr_wr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [19:0] mem_model(input logic [11:0] a);
        return (a == 12'h041) ? 20'h0ABCD : {8'h5A, a};
    endfunction

    assign cdata_rd = mem_model(caddr_rd);

    cmem_arbiter #(.N(4), .MAX_LOCK(4)) dut (
        .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_lock(req_lock),
        .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .csel(csel), .crd(crd), .cwr(cwr),
        .caddr_rd(caddr_rd), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .cdata_rd(cdata_rd)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        req = '0; req_we = '0; req_lock = '0;
        req_sel = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic set_req(input int k, input logic we, input logic lk, input logic [2:0] sel,
                           input logic [11:0] addr, input logic [19:0] wd);
        req[k] = 1'b1; req_we[k] = we; req_lock[k] = lk;
        req_sel[k*3 +: 3] = sel; req_addr[k*12 +: 12] = addr; req_wdata[k*20 +: 20] = wd;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, {28'd0, gnt}, 32'd0);
        chk({tag, "_rvalid"}, {28'd0, rvalid}, 32'd0);
        chk({tag, "_rdata"}, {12'd0, rdata}, 32'd0);
        chk({tag, "_strobes"}, {29'd0, csel}, 32'd0);
        chk({tag, "_crd_cwr"}, {30'd0, crd, cwr}, 32'd0);
        chk({tag, "_addr"}, {8'd0, caddr_rd, caddr_wr}, 32'd0);
        chk({tag, "_wdata"}, {12'd0, cdata_wr}, 32'd0);
    endtask

    int seq [11] = '{3, 1, 1, 1, 1, 3, 1, 1, 1, 1, 3};

    initial begin
        reset = 1'b1;
        clear_req();
        req = 4'b1111;
        step();
        step();
        chk_all_zero("reset");
        clear_req();
        reset = 1'b0;

        // Read path: requester 1 at ptr 0
        set_req(1, 1'b0, 1'b0, CSEL_L0, 12'h041, 20'h0);
        #1 chk("rd_gnt", {28'd0, gnt}, 32'h2);
        step();
        clear_req();
        #1;
        chk("rd_crd_cwr", {30'd0, crd, cwr}, 32'h2);
        chk("rd_caddr", {20'd0, caddr_rd}, 32'h041);
        chk("rd_csel", {29'd0, csel}, 32'h1);
        chk("rd_rvalid_t1", {28'd0, rvalid}, 32'h0);
        step();
        chk("rd_rvalid_t2", {28'd0, rvalid}, 32'h2);
        chk("rd_rdata", {12'd0, rdata}, 32'h0ABCD);
        chk("rd_crd_off", {30'd0, crd, cwr}, 32'h0);

        // Write path: requester 0, ptr now 2
        set_req(0, 1'b1, 1'b0, CSEL_L1, 12'hFFF, 20'h12345);
        #1 chk("wr_gnt", {28'd0, gnt}, 32'h1);
        step();
        clear_req();
        #1;
        chk("wr_crd_cwr", {30'd0, crd, cwr}, 32'h1);
        chk("wr_csel", {29'd0, csel}, 32'h2);
        chk("wr_caddr", {20'd0, caddr_wr}, 32'hFFF);
        chk("wr_cdata", {12'd0, cdata_wr}, 32'h12345);
        chk("wr_caddr_rd_hold", {20'd0, caddr_rd}, 32'h041);
        step();
        chk("wr_idle", {30'd0, crd, cwr}, 32'h0);
        chk("wr_rvalid", {28'd0, rvalid}, 32'h0);
        chk("wr_rdata_hold", {12'd0, rdata}, 32'h0ABCD);

        // Reset mid-read: requester 1 at ptr 1
        set_req(1, 1'b0, 1'b0, CSEL_L0, 12'h022, 20'h0);
        #1 chk("rst_gnt", {28'd0, gnt}, 32'h2);
        step();
        reset = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        step();
        chk_all_zero("rst_hold");
        clear_req();
        reset = 1'b0;
        step();
        chk("rst_rvalid_after", {28'd0, rvalid}, 32'h0);

        // Fairness: all four requesting, even ones write, odd ones read
        for (int k = 0; k < 4; k++)
            set_req(k, (k % 2) == 0, 1'b0, CSEL_L0, 12'h100 + 12'(k), 20'h00100 + 20'(k));
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("rr_gnt%0d", i), {28'd0, gnt}, 32'h1 << (i % 4));
            if (i > 0)
                chk($sformatf("rr_cmd%0d", i), {30'd0, crd, cwr},
                    (((i - 1) % 4) % 2 == 1) ? 32'h2 : 32'h1);
            if (i > 1)
                chk($sformatf("rr_rvalid%0d", i), {28'd0, rvalid},
                    (((i - 2) % 4) % 2 == 1) ? (32'h1 << ((i - 2) % 4)) : 32'h0);
            step();
        end
        clear_req();
        #1;
        chk("rr_last_cmd", {30'd0, crd, cwr}, 32'h2);
        chk("rr_last_addr", {20'd0, caddr_rd}, 32'h103);
        step();
        chk("rr_last_rvalid", {28'd0, rvalid}, 32'h8);
        chk("rr_last_rdata", {12'd0, rdata}, {12'd0, mem_model(12'h103)});
        step();

        // Locked 2x2 burst by requester 1 while 2 waits; ptr is 0
        set_req(1, 1'b0, 1'b1, CSEL_POOL0, 12'h200, 20'h0);
        set_req(2, 1'b0, 1'b0, CSEL_POOL1, 12'h300, 20'h0);
        for (int i = 0; i < 4; i++) begin
            req_addr[12 +: 12] = 12'h200 + 12'(i);
            req_lock[1] = (i < 3);
            #1;
            chk($sformatf("burst_gnt%0d", i), {28'd0, gnt}, 32'h2);
            chk($sformatf("burst_rvalid%0d", i), {28'd0, rvalid}, (i >= 2) ? 32'h2 : 32'h0);
            step();
        end
        req[1] = 1'b0;
        #1;
        chk("burst_gnt_after", {28'd0, gnt}, 32'h4);
        chk("burst_rvalid4", {28'd0, rvalid}, 32'h2);
        chk("burst_rdata4", {12'd0, rdata}, {12'd0, mem_model(12'h202)});
        step();
        clear_req();
        #1;
        chk("burst_rvalid5", {28'd0, rvalid}, 32'h2);
        chk("burst_rdata5", {12'd0, rdata}, {12'd0, mem_model(12'h203)});
        step();
        chk("burst_rvalid6", {28'd0, rvalid}, 32'h4);
        chk("burst_rdata6", {12'd0, rdata}, {12'd0, mem_model(12'h300)});

        // Lock cap: requester 1 locks forever, 3 writes; ptr is 3
        set_req(3, 1'b1, 1'b0, CSEL_FLAT, 12'h3C0, 20'h0BEEF);
        set_req(1, 1'b0, 1'b1, CSEL_POOL0, 12'h210, 20'h0);
        for (int i = 0; i < 11; i++) begin
            #1;
            chk($sformatf("cap_gnt%0d", i), {28'd0, gnt}, 32'h1 << seq[i]);
            step();
        end
        clear_req();
        #1;
        chk("cap_last_cmd", {30'd0, crd, cwr}, 32'h1);
        chk("cap_last_wdata", {12'd0, cdata_wr}, 32'h0BEEF);
        chk("cap_last_csel", {29'd0, csel}, 32'h5);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmem_arbiter.md
# cmem_arbiter

Round-robin arbiter that shares the single layer-memory port (csel/crd/cwr/caddr_rd/caddr_wr/cdata_wr/cdata_rd) among N requesters. The requesters are the conv/ReLU writer, max-pool reader, max-pool writer and flatten writer. It sits between those engines and the testbench-side layer memory. It issues one memory command per cycle, returns read data with fixed latency, and supports short locked bursts so the pooling reader can fetch a 2x2 window back-to-back.

## Interface
- N, 4: number of requesters (2..8).
- MAX_LOCK, 4: maximum consecutive grants a locked requester may hold.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  N  per-requester request.
- req_we  in  N  1 = write, 0 = read.
- req_lock  in  N  requester wants to keep the port after this grant.
- req_sel  in  3N  layer select (001 L0, 010 L1, 011 L2-pool0, 100 L2-pool1, 101 flatten), slice k = [3k+2:3k].
- req_addr  in  12N  address {row[5:0], col[5:0]}.
- req_wdata  in  20N  write data.
- gnt  out  N  one-hot grant, combinational, same cycle as accepted req.
- rvalid  out  N  one-hot, read data for requester k valid on rdata.
- rdata  out  20  registered read data.
- csel  out  3  memory select, registered.
- crd  out  1  memory read strobe, registered.
- cwr  out  1  memory write strobe, registered.
- caddr_rd  out  12  registered read address.
- caddr_wr  out  12  registered write address.
- cdata_wr  out  20  registered write data.
- cdata_rd  in  20  memory read data, valid in the cycle crd is high (combinational memory).

## Operation
- A request is accepted when req[k] && gnt[k]. The requester holds req, we, sel, addr and wdata stable until then.
- **Arbitration (combinational):** priority starts at pointer ptr and scans ptr, ptr+1, …, N-1, 0, …; the first active req wins. At most one gnt bit is high.
- **Pointer update:** after a grant to k, ptr <= (k+1) mod N. With no grant, ptr holds.
- **Lock:** when k is granted with req_lock[k]=1, lock_owner <= k and lock_cnt increments.
  - While locked and req[k]=1, gnt = k regardless of ptr.
  - The lock releases on any of:
    - k granted with req_lock[k]=0;
    - req[k]=0 in a cycle (that cycle is arbitrated normally);
    - lock_cnt reaching MAX_LOCK. That arbitration ignores the lock and ptr = k+1, so others win if they request.
  - The pointer does not advance during locked grants. It advances once on release.
- **Command issue:** in the cycle after acceptance, the registered outputs present the command:
  - csel = sel;
  - write: cwr=1, crd=0, caddr_wr = addr, cdata_wr = wdata;
  - read: crd=1, cwr=0, caddr_rd = addr.
  - With no acceptance, the next cycle has crd=cwr=0, and csel/addresses/data hold their previous values.
- **Read return:** in the cycle crd=1, cdata_rd is captured. rdata <= cdata_rd and rvalid <= one-hot(tag) on the following edge. Otherwise rvalid = 0 and rdata holds.
- **Reset** (any time, including mid-lock or with a read in flight):
  - gnt=0 while reset is asserted;
  - rvalid=0, rdata=0, csel=0, crd=0, cwr=0, caddr_rd=0, caddr_wr=0, cdata_wr=0;
  - ptr=0, lock cleared, lock_cnt=0, in-flight read tag discarded.

## Timing
- Grant: 0 cycles (same cycle as req).
- Memory command: cycle T+1 after acceptance at T.
- Read data: rdata/rvalid in cycle T+2. The pipeline is fully throughput-1, with back-to-back reads giving back-to-back rvalid.
- A read followed by a write in consecutive cycles is legal. Strobes are never both high.
- lock_cnt counts granted cycles of the current owner. It resets on release.

## Structure
- A shared package holds:
  - csel codes CSEL_L0=3'b001, CSEL_L1=3'b010, CSEL_POOL0=3'b011, CSEL_POOL1=3'b100, CSEL_FLAT=3'b101;
  - widths ADDR_W=12, DATA_W=20.
- One sub-module, rr_pick: combinational round-robin priority encoder with inputs (req, ptr) and outputs (gnt one-hot, idx).
- Lock, command registers and read-tag pipeline live in cmem_arbiter.

## Test plan
- **Reset mid-read:** req[1] read granted at T, reset asserted at T+1 → rvalid stays 0 and all outputs 0. After release, ptr=0.
- **Round-robin fairness:** req=4'b1111 held 8 cycles, no lock → gnt sequence 0001, 0010, 0100, 1000, 0001, … with exactly one command per cycle.
- **Read path:** req[1] read, sel=001, addr=12'h041, memory returns 20'h0ABCD → caddr_rd=12'h041 and crd=1 at T+1; rdata=20'h0ABCD and rvalid=0010 at T+2.
- **Write path:** req[0] write, sel=010, addr=12'hFFF, wdata=20'h12345 → cwr=1, csel=010, caddr_wr=12'hFFF, cdata_wr=20'h12345 at T+1, with crd=0.
- **Locked 2x2 burst:** req[1] locks for 4 reads while req[2] requests → gnt=0010 for 4 consecutive cycles, then 0100. rvalid=0010 on 4 consecutive cycles.
- **Lock starvation cap:** req[1] locked indefinitely, MAX_LOCK=4, req[3] active → after 4 grants to 1, the next grant goes to 3, then 1 may re-acquire.
